// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between the IF (fetch) port
// and the MEM (load/store) port. Each access lasts WAIT_CYCLES cycles, followed
// by a one-cycle ready pulse on the granted port. Data wins ties unless the
// previous grant went to data and a fetch is waiting, so IF waits for at most
// one data access.
module mem_port_arbiter #(
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        if_stall,
   output logic        mem_stall,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic        sram_we,
   output logic        sram_oe,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic       GNT_INST = 1'b0;
   localparam logic       GNT_DATA = 1'b1;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic data_req;
   logic in_access;

   assign data_req  = mem_r_en | mem_w_en;
   assign in_access = (state_q == ACCESS);

   // State, latched request and read-data registers; reset aborts any access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= GNT_INST;
         last_q      <= GNT_INST;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Arbitration in IDLE, wait countdown in ACCESS, single ready cycle in RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: begin
            if (data_req || if_req) begin
               state_d = ACCESS;
               cnt_d   = CNT_LOAD;
               if (data_req && !(last_q == GNT_DATA && if_req)) begin
                  grant_d = GNT_DATA;
                  addr_d  = mem_addr;
                  wdata_d = mem_wdata;
                  // A simultaneous read+write request is a write.
                  we_d    = mem_w_en;
               end else begin
                  grant_d = GNT_INST;
                  addr_d  = if_addr;
                  wdata_d = '0;
                  we_d    = 1'b0;
               end
               last_d = grant_d;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (grant_q == GNT_INST) if_rdata_d  = sram_rdata;
                  else                     mem_rdata_d = sram_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign sram_oe    = in_access & ~we_q;
   assign sram_we    = in_access &  we_q;
   assign sram_addr  = in_access ? addr_q  : '0;
   assign sram_wdata = in_access ? wdata_q : '0;

   assign if_ready  = (state_q == RESP) & (grant_q == GNT_INST);
   assign mem_ready = (state_q == RESP) & (grant_q == GNT_DATA);
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

   assign if_stall  = if_req   & ~if_ready;
   assign mem_stall = data_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (WAIT_CYCLES=3): requesters push the
// expected ready cycle and read data, the monitor pops on every ready pulse.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        if_stall;
   logic        mem_stall;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_we;
   logic        sram_oe;
   logic [31:0] sram_rdata;

   mem_port_arbiter #(.WAIT_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .if_stall(if_stall), .mem_stall(mem_stall),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_oe(sram_oe),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Read-only SRAM contents: one known instruction word, a pattern elsewhere.
   function automatic logic [31:0] sram_f(input logic [31:0] a);
      if (a == 32'h10) return 32'hE3A00001;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign sram_rdata = sram_oe ? sram_f(sram_addr) : 32'h0;

   typedef struct {
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        exp_if[$];
   exp_t        exp_mem[$];
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   int          we_cnt = 0;
   logic [31:0] wr_addr_exp = '0;
   logic [31:0] wr_data_exp = '0;
   logic [31:0] last_mem_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Per-cycle monitor: stall formulas, write data, and ready pulses vs scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("if_stall", 32'(if_stall), 32'(if_req & ~if_ready));
         chk("mem_stall", 32'(mem_stall), 32'((mem_r_en | mem_w_en) & ~mem_ready));
         chk("we_oe_excl", 32'(sram_we & sram_oe), 32'h0);
         if (sram_we) begin
            we_cnt++;
            chk("wr_addr", sram_addr, wr_addr_exp);
            chk("wr_data", sram_wdata, wr_data_exp);
         end
         if (if_ready) begin
            if (exp_if.size() == 0) chk("if_ready_unexp", 32'h1, 32'h0);
            else begin
               e = exp_if.pop_front();
               chk("if_ready_cyc", 32'(cyc), 32'(e.cyc));
               chk("if_rdata", if_rdata, e.rdata);
            end
         end
         if (mem_ready) begin
            if (exp_mem.size() == 0) chk("mem_ready_unexp", 32'h1, 32'h0);
            else begin
               e = exp_mem.pop_front();
               chk("mem_ready_cyc", 32'(cyc), 32'(e.cyc));
               chk("mem_rdata", mem_rdata, e.rdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic if_access(input logic [31:0] a, input int lat);
      exp_t e;
      int   n;
      if_req  = 1'b1;
      if_addr = a;
      e.rdata = sram_f(a);
      e.cyc   = cyc + lat;
      exp_if.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!if_ready && n < 60);
      if (!if_ready) chk("if_timeout", 32'h0, 32'h1);
      tick();
      if_req  = 1'b0;
      if_addr = '0;
   endtask

   task automatic mem_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input int lat);
      exp_t e;
      int   n;
      mem_r_en    = rd;
      mem_w_en    = wr;
      mem_addr    = a;
      mem_wdata   = wd;
      wr_addr_exp = a;
      wr_data_exp = wd;
      if (!wr) last_mem_rd = sram_f(a);
      e.rdata = last_mem_rd;
      e.cyc   = cyc + lat;
      exp_mem.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_ready && n < 60);
      if (!mem_ready) chk("mem_timeout", 32'h0, 32'h1);
      tick();
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
   endtask

   // SRAM strobes/address over request cycle and the four cycles after it.
   task automatic probe(input bit exp_we, input bit exp_oe, input logic [31:0] a);
      bit act;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         act = (k >= 1 && k <= 3);
         chk("probe_we", 32'(sram_we), 32'(exp_we & act));
         chk("probe_oe", 32'(sram_oe), 32'(exp_oe & act));
         chk("probe_addr", sram_addr, act ? a : 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      // Reset with random inputs present.
      if_req    = 1'($urandom);
      if_addr   = $urandom;
      mem_r_en  = 1'($urandom);
      mem_w_en  = 1'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      tick();
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
      mem_addr = '0; mem_wdata = '0;
      @(negedge clk);
      chk("rst_if_ready", 32'(if_ready), 32'h0);
      chk("rst_mem_ready", 32'(mem_ready), 32'h0);
      chk("rst_sram_we", 32'(sram_we), 32'h0);
      chk("rst_sram_oe", 32'(sram_oe), 32'h0);
      chk("rst_sram_addr", sram_addr, 32'h0);
      chk("rst_sram_wdata", sram_wdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      mon_en = 1'b1;
      tick();

      // Instruction fetch.
      fork
         if_access(32'h10, 4);
         probe(1'b0, 1'b1, 32'h10);
      join
      repeat (2) tick();

      // Data write: three write cycles, load data untouched.
      we_cnt = 0;
      fork
         mem_access(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 4);
         probe(1'b1, 1'b0, 32'h400);
      join
      chk("wr_cycles", 32'(we_cnt), 32'd3);
      repeat (2) tick();

      // Reset in the second access cycle of a write aborts it.
      mem_w_en = 1'b1; mem_addr = 32'h404; mem_wdata = 32'h0BADF00D;
      wr_addr_exp = 32'h404; wr_data_exp = 32'h0BADF00D;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("abort_we_before", 32'(sram_we), 32'h1);
      tick();
      rst = 1'b0;
      mem_w_en = 1'b0; mem_addr = '0; mem_wdata = '0;
      @(negedge clk);
      chk("abort_we_after", 32'(sram_we), 32'h0);
      chk("abort_oe_after", 32'(sram_oe), 32'h0);
      chk("abort_no_ready", 32'(mem_ready), 32'h0);
      repeat (6) tick();

      // Simultaneous IF and data read: data first, IF right after.
      fork
         mem_access(1'b1, 1'b0, 32'h200, 32'h0, 4);
         if_access(32'h40, 9);
      join
      tick();

      // IF held against back-to-back data reads: grants alternate.
      fork
         begin
            mem_access(1'b1, 1'b0, 32'h300, 32'h0, 4);
            mem_access(1'b1, 1'b0, 32'h304, 32'h0, 9);
         end
         begin
            if_access(32'h20, 9);
            if_access(32'h24, 9);
         end
      join
      tick();

      // Read and write together behave as a write.
      we_cnt = 0;
      fork
         mem_access(1'b1, 1'b1, 32'h500, 32'h12345678, 4);
         probe(1'b1, 1'b0, 32'h500);
      join
      chk("rw_cycles", 32'(we_cnt), 32'd3);

      repeat (3) tick();
      chk("if_queue_empty", 32'(exp_if.size()), 32'h0);
      chk("mem_queue_empty", 32'(exp_mem.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
